// File: rtl/retire_trace_monitor.sv
// retire_trace_monitor
// Passive shadow of the RV12 IF..WB pipeline. Tracks pc/insn/bubble per stage
// from IF fetch data plus stall/flush/exception, and emits one registered
// retirement record per committed instruction. The next-pc of a record is only
// known at the following retirement, so one record is always held pending.
// Never drives the core.
module retire_trace_monitor #(
    parameter logic [31:0] PC_INIT  = 32'h0000_0200,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_insn_i,
    input  logic        if_bubble_i,
    input  logic        id_stall_i,
    input  logic        bu_flush_i,
    input  logic        ex_exception_i,

    input  logic        wb_we_i,
    input  logic [4:0]  wb_dst_i,
    input  logic [31:0] wb_r_i,

    output logic        rv_valid_o,
    output logic [63:0] rv_order_o,
    output logic [31:0] rv_insn_o,
    output logic [31:0] rv_pc_rdata_o,
    output logic [31:0] rv_pc_wdata_o,
    output logic [4:0]  rv_rd_addr_o,
    output logic [31:0] rv_rd_wdata_o
);

    // ------------------------------------------------------------------
    // Shadow pipeline state
    // ------------------------------------------------------------------
    logic [31:0] pd_pc_q,   pd_pc_d;
    logic [31:0] pd_insn_q, pd_insn_d;
    logic        pd_bubble_q, pd_bubble_d;

    logic [31:0] id_pc_q,   id_pc_d;
    logic [31:0] id_insn_q, id_insn_d;
    logic        id_bubble_q, id_bubble_d;

    logic [31:0] ex_pc_q,   ex_pc_d;
    logic [31:0] ex_insn_q, ex_insn_d;
    logic        ex_bubble_q, ex_bubble_d;

    logic [31:0] mem_pc_q,   mem_pc_d;
    logic [31:0] mem_insn_q, mem_insn_d;
    logic        mem_bubble_q, mem_bubble_d;

    logic [31:0] wb_pc_q,   wb_pc_d;
    logic [31:0] wb_insn_q, wb_insn_d;
    logic        wb_bubble_q, wb_bubble_d;

    // ------------------------------------------------------------------
    // Pending record (waiting for its next-pc) and output registers
    // ------------------------------------------------------------------
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q,    pend_pc_d;
    logic [31:0] pend_insn_q,  pend_insn_d;
    logic [4:0]  pend_rd_q,    pend_rd_d;
    logic [31:0] pend_wdata_q, pend_wdata_d;

    logic [63:0] order_q, order_d;

    logic        rv_valid_q,    rv_valid_d;
    logic [63:0] rv_order_q,    rv_order_d;
    logic [31:0] rv_insn_q,     rv_insn_d;
    logic [31:0] rv_pc_rdata_q, rv_pc_rdata_d;
    logic [31:0] rv_pc_wdata_q, rv_pc_wdata_d;
    logic [4:0]  rv_rd_addr_q,  rv_rd_addr_d;
    logic [31:0] rv_rd_wdata_q, rv_rd_wdata_d;

    logic        capture;
    logic        emit;
    logic [4:0]  cap_rd;
    logic [31:0] cap_wdata;

    // Next state of PD and ID: both freeze their payload on an ID stall.
    // A stall still bubbles ID because the instruction it held moves into EX.
    always_comb begin
        pd_pc_d     = pd_pc_q;
        pd_insn_d   = pd_insn_q;
        pd_bubble_d = pd_bubble_q;
        id_pc_d     = id_pc_q;
        id_insn_d   = id_insn_q;

        if (!id_stall_i) begin
            pd_pc_d   = if_pc_i & ~32'h0000_0003;
            pd_insn_d = if_insn_i;
            id_pc_d   = pd_pc_q;
            id_insn_d = pd_insn_q;
        end

        if (bu_flush_i || ex_exception_i) begin
            pd_bubble_d = 1'b1;
        end else if (!id_stall_i) begin
            pd_bubble_d = if_bubble_i;
        end

        id_bubble_d = (bu_flush_i || id_stall_i || ex_exception_i) ? 1'b1 : pd_bubble_q;
    end

    // Next state of EX, MEM and WB: advance every cycle; EX is killed by an exception.
    always_comb begin
        ex_pc_d      = id_pc_q;
        ex_insn_d    = id_insn_q;
        ex_bubble_d  = ex_exception_i ? 1'b1 : id_bubble_q;

        mem_pc_d     = ex_pc_q;
        mem_insn_d   = ex_insn_q;
        mem_bubble_d = ex_bubble_q;

        wb_pc_d      = mem_pc_q;
        wb_insn_d    = mem_insn_q;
        wb_bubble_d  = mem_bubble_q;
    end

    // Shadow pipeline registers, reset to a column of bubbled NOPs at PC_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_pc_q      <= PC_INIT;
            pd_insn_q    <= NOP_INSN;
            pd_bubble_q  <= 1'b1;
            id_pc_q      <= PC_INIT;
            id_insn_q    <= NOP_INSN;
            id_bubble_q  <= 1'b1;
            ex_pc_q      <= PC_INIT;
            ex_insn_q    <= NOP_INSN;
            ex_bubble_q  <= 1'b1;
            mem_pc_q     <= PC_INIT;
            mem_insn_q   <= NOP_INSN;
            mem_bubble_q <= 1'b1;
            wb_pc_q      <= PC_INIT;
            wb_insn_q    <= NOP_INSN;
            wb_bubble_q  <= 1'b1;
        end else begin
            pd_pc_q      <= pd_pc_d;
            pd_insn_q    <= pd_insn_d;
            pd_bubble_q  <= pd_bubble_d;
            id_pc_q      <= id_pc_d;
            id_insn_q    <= id_insn_d;
            id_bubble_q  <= id_bubble_d;
            ex_pc_q      <= ex_pc_d;
            ex_insn_q    <= ex_insn_d;
            ex_bubble_q  <= ex_bubble_d;
            mem_pc_q     <= mem_pc_d;
            mem_insn_q   <= mem_insn_d;
            mem_bubble_q <= mem_bubble_d;
            wb_pc_q      <= wb_pc_d;
            wb_insn_q    <= wb_insn_d;
            wb_bubble_q  <= wb_bubble_d;
        end
    end

    // Retirement capture: the WB shadow holds a live instruction. Writes to x0
    // and non-writing instructions both report rd 0 with zero data.
    always_comb begin
        capture   = !wb_bubble_q;
        emit      = capture && pend_valid_q;
        cap_rd    = (wb_we_i && (wb_dst_i != 5'd0)) ? wb_dst_i : 5'd0;
        cap_wdata = (cap_rd != 5'd0) ? wb_r_i : 32'd0;
    end

    // Pending buffer and output record next state: emit the old pending record
    // (its next-pc is the pc now retiring), then replace it with the new one.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        pend_insn_d   = pend_insn_q;
        pend_rd_d     = pend_rd_q;
        pend_wdata_d  = pend_wdata_q;
        order_d       = order_q;

        rv_valid_d    = 1'b0;
        rv_order_d    = rv_order_q;
        rv_insn_d     = rv_insn_q;
        rv_pc_rdata_d = rv_pc_rdata_q;
        rv_pc_wdata_d = rv_pc_wdata_q;
        rv_rd_addr_d  = rv_rd_addr_q;
        rv_rd_wdata_d = rv_rd_wdata_q;

        if (emit) begin
            rv_valid_d    = 1'b1;
            rv_order_d    = order_q;
            rv_insn_d     = pend_insn_q;
            rv_pc_rdata_d = pend_pc_q;
            rv_pc_wdata_d = wb_pc_q;
            rv_rd_addr_d  = pend_rd_q;
            rv_rd_wdata_d = pend_wdata_q;
            order_d       = order_q + 64'd1;
        end

        if (capture) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = wb_pc_q;
            pend_insn_d  = wb_insn_q;
            pend_rd_d    = cap_rd;
            pend_wdata_d = cap_wdata;
        end
    end

    // Pending buffer, order counter and registered record outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= 32'd0;
            pend_insn_q   <= 32'd0;
            pend_rd_q     <= 5'd0;
            pend_wdata_q  <= 32'd0;
            order_q       <= 64'd0;
            rv_valid_q    <= 1'b0;
            rv_order_q    <= 64'd0;
            rv_insn_q     <= 32'd0;
            rv_pc_rdata_q <= 32'd0;
            rv_pc_wdata_q <= 32'd0;
            rv_rd_addr_q  <= 5'd0;
            rv_rd_wdata_q <= 32'd0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
            pend_insn_q   <= pend_insn_d;
            pend_rd_q     <= pend_rd_d;
            pend_wdata_q  <= pend_wdata_d;
            order_q       <= order_d;
            rv_valid_q    <= rv_valid_d;
            rv_order_q    <= rv_order_d;
            rv_insn_q     <= rv_insn_d;
            rv_pc_rdata_q <= rv_pc_rdata_d;
            rv_pc_wdata_q <= rv_pc_wdata_d;
            rv_rd_addr_q  <= rv_rd_addr_d;
            rv_rd_wdata_q <= rv_rd_wdata_d;
        end
    end

    assign rv_valid_o    = rv_valid_q;
    assign rv_order_o    = rv_order_q;
    assign rv_insn_o     = rv_insn_q;
    assign rv_pc_rdata_o = rv_pc_rdata_q;
    assign rv_pc_wdata_o = rv_pc_wdata_q;
    assign rv_rd_addr_o  = rv_rd_addr_q;
    assign rv_rd_wdata_o = rv_rd_wdata_q;

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed bench for retire_trace_monitor: a cycle table for the basic record
// stream and rd masking, plus hand sequences for stall, flush, exception and
// mid-run reset, checked against a log of emitted records.
module tb_retire_trace_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc_i;
    logic [31:0] if_insn_i;
    logic        if_bubble_i;
    logic        id_stall_i;
    logic        bu_flush_i;
    logic        ex_exception_i;
    logic        wb_we_i;
    logic [4:0]  wb_dst_i;
    logic [31:0] wb_r_i;
    logic        rv_valid_o;
    logic [63:0] rv_order_o;
    logic [31:0] rv_insn_o;
    logic [31:0] rv_pc_rdata_o;
    logic [31:0] rv_pc_wdata_o;
    logic [4:0]  rv_rd_addr_o;
    logic [31:0] rv_rd_wdata_o;

    always #5 clk = ~clk;

    retire_trace_monitor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc_i        (if_pc_i),
        .if_insn_i      (if_insn_i),
        .if_bubble_i    (if_bubble_i),
        .id_stall_i     (id_stall_i),
        .bu_flush_i     (bu_flush_i),
        .ex_exception_i (ex_exception_i),
        .wb_we_i        (wb_we_i),
        .wb_dst_i       (wb_dst_i),
        .wb_r_i         (wb_r_i),
        .rv_valid_o     (rv_valid_o),
        .rv_order_o     (rv_order_o),
        .rv_insn_o      (rv_insn_o),
        .rv_pc_rdata_o  (rv_pc_rdata_o),
        .rv_pc_wdata_o  (rv_pc_wdata_o),
        .rv_rd_addr_o   (rv_rd_addr_o),
        .rv_rd_wdata_o  (rv_rd_wdata_o)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        bub;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] r;
        logic        e_valid;
        logic [63:0] e_order;
        logic [31:0] e_pcr;
        logic [31:0] e_pcw;
        logic [31:0] e_insn;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    typedef struct {
        logic [63:0] order;
        logic [31:0] pcr;
        logic [31:0] pcw;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] wd;
    } rec_t;

    vec_t tbl[$];
    rec_t recs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Log every emitted record, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && rv_valid_o) begin
            rec_t r;
            r.order = rv_order_o;
            r.pcr   = rv_pc_rdata_o;
            r.pcw   = rv_pc_wdata_o;
            r.insn  = rv_insn_o;
            r.rd    = rv_rd_addr_o;
            r.wd    = rv_rd_wdata_o;
            recs.push_back(r);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] insn, input logic bub,
                         input logic stall, input logic flush, input logic exc,
                         input logic we, input logic [4:0] dst, input logic [31:0] r);
        if_pc_i        = pc;
        if_insn_i      = insn;
        if_bubble_i    = bub;
        id_stall_i     = stall;
        bu_flush_i     = flush;
        ex_exception_i = exc;
        wb_we_i        = we;
        wb_dst_i       = dst;
        wb_r_i         = r;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] insn);
        drive(pc, insn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) begin
            drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            step();
        end
    endtask

    task automatic do_reset();
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        recs.delete();
    endtask

    task automatic add(input logic rst, input logic [31:0] pc, input logic [31:0] insn,
                       input logic bub, input logic we, input logic [4:0] dst, input logic [31:0] r,
                       input logic ev, input logic [63:0] eo, input logic [31:0] epr,
                       input logic [31:0] epw, input logic [31:0] ein, input logic [4:0] erd,
                       input logic [31:0] ewd);
        vec_t v;
        v.rst = rst; v.pc = pc; v.insn = insn; v.bub = bub; v.we = we; v.dst = dst; v.r = r;
        v.e_valid = ev; v.e_order = eo; v.e_pcr = epr; v.e_pcw = epw;
        v.e_insn = ein; v.e_rd = erd; v.e_wd = ewd;
        tbl.push_back(v);
    endtask

    task automatic chk_rec(input string tag, input int idx, input logic [63:0] order,
                           input logic [31:0] pcr, input logic [31:0] pcw, input logic [31:0] insn,
                           input logic [4:0] rd, input logic [31:0] wd);
        if (idx >= recs.size()) begin
            n_checks++;
            n_err++;
            $display("FAIL %s rec%0d: missing, got %0d records", tag, idx, recs.size());
        end else begin
            chk($sformatf("%s rec%0d order", tag, idx), recs[idx].order, order);
            chk($sformatf("%s rec%0d pc_rdata", tag, idx), {32'd0, recs[idx].pcr}, {32'd0, pcr});
            chk($sformatf("%s rec%0d pc_wdata", tag, idx), {32'd0, recs[idx].pcw}, {32'd0, pcw});
            chk($sformatf("%s rec%0d insn", tag, idx), {32'd0, recs[idx].insn}, {32'd0, insn});
            chk($sformatf("%s rec%0d rd_addr", tag, idx), {59'd0, recs[idx].rd}, {59'd0, rd});
            chk($sformatf("%s rec%0d rd_wdata", tag, idx), {32'd0, recs[idx].wd}, {32'd0, wd});
        end
    endtask

    vec_t v;
    int   hits;

    initial begin
        // Row layout: rst, if_pc, if_insn, if_bubble, wb_we, wb_dst, wb_r |
        //             valid, order, pc_rdata, pc_wdata, insn, rd, rd_wdata
        // addi x5 at 0x200, nops at 0x204/0x208; first capture 5 edges after entry.
        add(0, 32'h200, 32'h00700293, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h204, 32'h00000013, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h208, 32'h00000013, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 1, 5, 7,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     1, 0, 32'h200, 32'h204, 32'h00700293, 5, 7);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     1, 1, 32'h204, 32'h208, 32'h00000013, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     0, 1, 32'h204, 32'h208, 32'h00000013, 0, 0);
        // Reset clears outputs; then rd masking: write to x0, and dst 3 without write enable.
        add(1, 32'h0,   32'h0,        1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h200, 32'h05500013, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h204, 32'h00300193, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h208, 32'h00000013, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 3, 32'h99, 1, 0, 32'h200, 32'h204, 32'h05500013, 0, 0);
        add(0, 32'h0,   32'h0,        1, 1, 7, 32'h1234, 1, 1, 32'h204, 32'h208, 32'h00300193, 0, 0);
        add(0, 32'h0,   32'h0,        1, 0, 0, 0,     0, 1, 32'h204, 32'h208, 32'h00300193, 0, 0);

        // Reset with the pipeline idle: outputs stay zero for 20 cycles.
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        step();
        step();
        chk("in reset valid", {63'd0, rv_valid_o}, 64'd0);
        chk("in reset order", rv_order_o, 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(32'h200 + 32'(k * 4), 32'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hAA);
            step();
            chk($sformatf("idle%0d valid", k), {63'd0, rv_valid_o}, 64'd0);
            chk($sformatf("idle%0d fields", k), {63'd0, |{rv_order_o, rv_insn_o, rv_pc_rdata_o,
                rv_pc_wdata_o, rv_rd_addr_o, rv_rd_wdata_o}}, 64'd0);
        end

        // Table-driven cycles.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.pc, v.insn, v.bub, 1'b0, 1'b0, 1'b0, v.we, v.dst, v.r);
            if (v.rst) rst_n = 1'b0;
            step();
            chk($sformatf("vec%0d valid", i), {63'd0, rv_valid_o}, {63'd0, v.e_valid});
            chk($sformatf("vec%0d order", i), rv_order_o, v.e_order);
            chk($sformatf("vec%0d pc_rdata", i), {32'd0, rv_pc_rdata_o}, {32'd0, v.e_pcr});
            chk($sformatf("vec%0d pc_wdata", i), {32'd0, rv_pc_wdata_o}, {32'd0, v.e_pcw});
            chk($sformatf("vec%0d insn", i), {32'd0, rv_insn_o}, {32'd0, v.e_insn});
            chk($sformatf("vec%0d rd_addr", i), {59'd0, rv_rd_addr_o}, {59'd0, v.e_rd});
            chk($sformatf("vec%0d rd_wdata", i), {32'd0, rv_rd_wdata_o}, {32'd0, v.e_wd});
            if (v.rst) rst_n = 1'b1;
        end

        // ID stall for 3 cycles with 0x204 held in PD; 0x210 stays pending.
        do_reset();
        put(32'h200, 32'h00100093);
        put(32'h204, 32'h00200113);
        for (int k = 0; k < 3; k++) begin
            drive(32'h208, 32'h00300193, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            step();
        end
        put(32'h208, 32'h00300193);
        put(32'h20C, 32'h00400213);
        put(32'h210, 32'h00500293);
        idle_n(12);
        chk("stall record count", 64'(recs.size()), 64'd4);
        chk_rec("stall", 0, 0, 32'h200, 32'h204, 32'h00100093, 0, 0);
        chk_rec("stall", 1, 1, 32'h204, 32'h208, 32'h00200113, 0, 0);
        chk_rec("stall", 2, 2, 32'h208, 32'h20C, 32'h00300193, 0, 0);
        chk_rec("stall", 3, 3, 32'h20C, 32'h210, 32'h00400213, 0, 0);

        // jal 0x210 -> 0x300; flush kills 0x214/0x218 as they enter ID/PD.
        do_reset();
        put(32'h210, 32'h0F0000EF);
        put(32'h214, 32'h00100093);
        drive(32'h218, 32'h00200113, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        put(32'h300, 32'h00000013);
        put(32'h304, 32'h00000013);
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h214);
        step();
        idle_n(12);
        chk("flush record count", 64'(recs.size()), 64'd2);
        chk_rec("flush", 0, 0, 32'h210, 32'h300, 32'h0F0000EF, 1, 32'h214);
        chk_rec("flush", 1, 1, 32'h300, 32'h304, 32'h00000013, 0, 0);
        hits = 0;
        foreach (recs[j]) if (recs[j].pcr == 32'h214 || recs[j].pcr == 32'h218) hits++;
        chk("flushed pc recorded", 64'(hits), 64'd0);

        // Exception in EX kills EX, ID and PD; MEM survives.
        do_reset();
        put(32'h200, 32'h00100093);
        put(32'h204, 32'h00200113);
        put(32'h208, 32'h00300193);
        drive(32'h20C, 32'h00400213, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step();
        put(32'h210, 32'h00500293);
        put(32'h214, 32'h00600313);
        idle_n(12);
        chk("exc record count", 64'(recs.size()), 64'd2);
        chk_rec("exc", 0, 0, 32'h200, 32'h210, 32'h00100093, 0, 0);
        chk_rec("exc", 1, 1, 32'h210, 32'h214, 32'h00500293, 0, 0);

        // Reset mid-stream while 0x204 is pending and a record is on the outputs.
        do_reset();
        put(32'h200, 32'h00100093);
        put(32'h204, 32'h00200113);
        put(32'h208, 32'h00300193);
        idle_n(4);
        chk("first record latency valid", {63'd0, rv_valid_o}, 64'd1);
        chk("first record latency pc", {32'd0, rv_pc_rdata_o}, 64'h200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset valid drop", {63'd0, rv_valid_o}, 64'd0);
        chk("async reset pc clear", {32'd0, rv_pc_rdata_o}, 64'd0);
        step();
        rst_n = 1'b1;
        recs.delete();
        put(32'h200, 32'h00000013);
        put(32'h204, 32'h00000013);
        put(32'h208, 32'h00000013);
        idle_n(12);
        chk("post reset record count", 64'(recs.size()), 64'd2);
        chk_rec("postrst", 0, 0, 32'h200, 32'h204, 32'h00000013, 0, 0);
        hits = 0;
        foreach (recs[j]) if (recs[j].insn != 32'h00000013) hits++;
        chk("stale pending emitted", 64'(hits), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
